// File: rtl/core_pkg.sv
// Shared types and constants for the instruction fetch slice.
//   XLEN          : architectural register / address width
//   OPC_JAL       : major opcode of JAL
//   NOP_INST      : canonical NOP (addi x0,x0,0) shown to the decoder when idle
//   fetch_entry_t : one buffered fetch result, {pc, inst}
//   jal_imm()     : sign-extended J-type immediate of an instruction word
package core_pkg;

    localparam int             XLEN     = 32;
    localparam logic [6:0]     OPC_JAL  = 7'b1101111;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] jal_imm(input logic [XLEN-1:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/core_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t.
//   CLK, RST_N : clock, synchronous active-low reset
//   push_i     : write wdata_i (accepted when not full, or full with a pop)
//   pop_i      : drop the head entry (ignored when empty)
//   flush_i    : empty the FIFO; wins over push/pop
//   wdata_i    : entry to write
//   rdata_o    : head entry (undefined when empty_o)
//   full_o, empty_o, count_o : occupancy status
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module core_fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_t               wdata_i,
    output fetch_entry_t               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge CLK) begin
        if (!RST_N || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    overflow_chk: assert property (@(posedge CLK) disable iff (!RST_N)
        !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/core_fetch.sv
// Instruction fetch stage. Owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PCs and presents one
// instruction per cycle to the decoder.
//   CLK, RST_N            : clock, synchronous active-low reset
//   IMEM_REQ/ADDR/GNT     : request handshake (ADDR held while REQ waits for GNT)
//   IMEM_RVALID/RDATA     : in-order responses, >= 1 cycle after GNT
//   REDIRECT/REDIRECT_PC  : restart fetch at a new PC, flushing everything
//   STALL                 : decoder back-pressure
//   INST/INST_PC/INST_VALID : buffer head; NOP and PC 0 when empty
// Optional build macro FETCH_JAL_PREDICT_EN: redirect fetch internally to the
// target of a returned JAL instead of waiting for the execute stage.
module core_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_GNT,
    input  logic            IMEM_RVALID,
    input  logic [XLEN-1:0] IMEM_RDATA,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_PC,
    input  logic            STALL,
    output logic [XLEN-1:0] INST,
    output logic [XLEN-1:0] INST_PC,
    output logic            INST_VALID
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    // Drops can pile up across repeated redirects against a slow memory.
    localparam int DW = CW + 4;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [DW-1:0]   drop_q, drop_d;

    fetch_entry_t    buf_head, pcq_head;
    logic            buf_full, buf_empty, pcq_full, pcq_empty;
    logic [CW-1:0]   occ, in_flight, credit_used;
    logic            resp_drop, resp_keep, pop, grant, jal_hit;
    logic            unused_fifo;

    assign resp_drop = IMEM_RVALID && (drop_q != '0);
    assign resp_keep = IMEM_RVALID && (drop_q == '0);
    assign pop       = !buf_empty && !STALL;

`ifdef FETCH_JAL_PREDICT_EN
    logic [XLEN-1:0] jal_target;
    assign jal_hit    = resp_keep && !REDIRECT && (IMEM_RDATA[6:0] == OPC_JAL);
    assign jal_target = pcq_head.pc + jal_imm(IMEM_RDATA);
`else
    assign jal_hit    = 1'b0;
`endif

    // Credit counts the slot freed by this cycle's pop so that a single-cycle
    // memory keeps one instruction per cycle flowing with only two entries.
    // occ + in_flight never exceeds BUF_DEPTH, so no push can meet a full buffer.
    assign credit_used = occ - CW'(pop) + in_flight;
    assign IMEM_REQ    = RST_N && !REDIRECT && !jal_hit && (credit_used < CW'(BUF_DEPTH));
    assign IMEM_ADDR   = pc_q;
    assign grant       = IMEM_REQ && IMEM_GNT;

    core_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (resp_keep && !REDIRECT),
        .pop_i   (pop && !REDIRECT),
        .flush_i (REDIRECT),
        .wdata_i ('{pc: pcq_head.pc, inst: IMEM_RDATA}),
        .rdata_o (buf_head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (occ)
    );

    // PCs of granted requests whose responses are still owed to the buffer.
    core_fetch_fifo #(.DEPTH(BUF_DEPTH)) u_pcq (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push_i  (grant),
        .pop_i   (resp_keep && !REDIRECT),
        .flush_i (REDIRECT || jal_hit),
        .wdata_i ('{pc: pc_q, inst: '0}),
        .rdata_o (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (in_flight)
    );

    assign unused_fifo = ^{pcq_head.inst, buf_full, pcq_full, pcq_empty};

    always_comb begin
        pc_d   = pc_q;
        drop_d = drop_q;
        if (REDIRECT) begin
            pc_d   = {REDIRECT_PC[XLEN-1:2], 2'b00};
            // Every response still owed by memory becomes a drop, less the
            // one (dropped or in-flight) that is being discarded right now.
            drop_d = drop_q + DW'(in_flight) - DW'(IMEM_RVALID);
        end
`ifdef FETCH_JAL_PREDICT_EN
        else if (jal_hit) begin
            pc_d   = jal_target;
            // The JAL is the oldest in-flight word; all younger ones are stale.
            drop_d = DW'(in_flight) - DW'(1);
        end
`endif
        else begin
            if (resp_drop) drop_d = drop_q - DW'(1);
            if (grant)     pc_d   = pc_q + 32'd4;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else begin
            pc_q   <= pc_d;
            drop_q <= drop_d;
        end
    end

    assign INST_VALID = !buf_empty;
    assign INST       = buf_empty ? NOP_INST : buf_head.inst;
    assign INST_PC    = buf_empty ? '0 : buf_head.pc;

endmodule

// File: tb/tb_core_fetch.sv
module tb_core_fetch;

    logic        CLK;
    logic        RST_N;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        STALL;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] JAL16 = 32'h0100_006F;  // jal x0, +16

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] jal_at = 32'hFFFF_FFFF;

    core_fetch dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_GNT    (IMEM_GNT),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .STALL       (STALL),
        .INST        (INST),
        .INST_PC     (INST_PC),
        .INST_VALID  (INST_VALID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == jal_at) ? JAL16 : a;
    endfunction

    // Instruction memory: returns the word address as data, fixed latency,
    // shares RST_N and forgets outstanding requests on reset.
    initial begin
        IMEM_RVALID = 1'b0;
        IMEM_RDATA  = 32'h0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RST_N) begin
                mq.delete();
                IMEM_RVALID = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                IMEM_RVALID = 1'b0;
                IMEM_RDATA  = 32'hDEAD_BEEF;
            end
            #1;
            if (RST_N && IMEM_REQ && IMEM_GNT) mq.push_back('{IMEM_ADDR, cyc + lat});
        end
    end

    // Ends at the negedge that starts cycle 0 with RST_N released.
    task automatic do_reset(input int l);
        @(negedge CLK);
        RST_N = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; STALL = 1'b0; IMEM_GNT = 1'b1;
        lat = l;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST_N = 1'b0; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; STALL = 1'b0; IMEM_GNT = 1'b1; lat = 1;
        @(negedge CLK); #2;
        n_cmp++; if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", INST_VALID); end
        n_cmp++; if (INST !== 32'h13) begin n_err++; $display("FAIL rst_inst: got %h want 00000013", INST); end
        n_cmp++; if (INST_PC !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", INST_PC); end
        n_cmp++; if (IMEM_REQ !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", IMEM_REQ); end
        @(negedge CLK); RST_N = 1'b1; #2;
        n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin n_err++; $display("FAIL rst_first_req: got %b/%h want 1/0", IMEM_REQ, IMEM_ADDR); end
        for (int c = 1; c <= 3; c++) @(negedge CLK);
        #2;
        n_cmp++; if (INST_PC !== 32'h4) begin n_err++; $display("FAIL rst_pre_mid: got %h want 4", INST_PC); end
        // reset in the middle of a stream
        @(negedge CLK); RST_N = 1'b0;
        @(negedge CLK); #2;
        n_cmp++; if (INST_VALID !== 1'b0 || INST !== 32'h13 || IMEM_REQ !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: got v=%b inst=%h req=%b want 0/00000013/0", INST_VALID, INST, IMEM_REQ); end
        @(negedge CLK); RST_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK); #2;
        n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h0 || INST !== 32'h0) begin
            n_err++; $display("FAIL rst_restart: got v=%b pc=%h inst=%h want 1/0/0", INST_VALID, INST_PC, INST); end
    endtask

    task automatic test_stream();
        do_reset(1);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge CLK);
            #2;
            n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'(4 * c)) begin
                n_err++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", c, IMEM_REQ, IMEM_ADDR, 32'(4 * c)); end
            if (c >= 2) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'(4 * (c - 2)) || INST !== 32'(4 * (c - 2))) begin
                    n_err++; $display("FAIL stream_inst c%0d: got v=%b pc=%h inst=%h want pc %h", c, INST_VALID, INST_PC, INST, 32'(4 * (c - 2))); end
            end else begin
                n_cmp++; if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL stream_early c%0d: got v=%b want 0", c, INST_VALID); end
            end
        end
    endtask

    task automatic test_stall();
        int exp_pc [13] = '{0, 0, 0, 4, 8, 8, 8, 8, 8, 8, 12, 16, 20};
        do_reset(1);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge CLK);
            STALL = (c >= 4 && c <= 8);
            #2;
            if (c >= 2) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'(exp_pc[c]) || INST !== 32'(exp_pc[c])) begin
                    n_err++; $display("FAIL stall_inst c%0d: got v=%b pc=%h inst=%h want pc %h", c, INST_VALID, INST_PC, INST, 32'(exp_pc[c])); end
            end
            if (c >= 4 && c <= 8) begin
                n_cmp++; if (IMEM_REQ !== 1'b0 || IMEM_ADDR !== 32'h10) begin
                    n_err++; $display("FAIL stall_req c%0d: got %b/%h want 0/00000010", c, IMEM_REQ, IMEM_ADDR); end
            end else begin
                n_cmp++; if (IMEM_REQ !== 1'b1) begin n_err++; $display("FAIL stall_req c%0d: got %b want 1", c, IMEM_REQ); end
            end
        end
        STALL = 1'b0;
    endtask

    task automatic test_redirect_latency();
        do_reset(3);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge CLK);
            REDIRECT    = (c == 2);
            REDIRECT_PC = 32'h100;
            #2;
            if (c == 2) begin
                n_cmp++; if (IMEM_REQ !== 1'b0) begin n_err++; $display("FAIL redir_req_off: got %b want 0", IMEM_REQ); end
            end
            if (c == 3) begin
                n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin
                    n_err++; $display("FAIL redir_new_addr: got %b/%h want 1/00000100", IMEM_REQ, IMEM_ADDR); end
            end
            if (c >= 3 && c <= 6) begin
                n_cmp++; if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL redir_drop c%0d: got v=%b pc=%h want invalid", c, INST_VALID, INST_PC); end
            end
            if (c == 7 || c == 8) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'(32'h100 + 4 * (c - 7)) || INST !== INST_PC) begin
                    n_err++; $display("FAIL redir_inst c%0d: got v=%b pc=%h inst=%h want pc %h", c, INST_VALID, INST_PC, INST, 32'(32'h100 + 4 * (c - 7))); end
            end
        end
        REDIRECT = 1'b0;
    endtask

    task automatic test_redirect_resp_pop();
        do_reset(1);
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) @(negedge CLK);
            REDIRECT    = (c == 3);
            REDIRECT_PC = 32'h40;
            #2;
            if (c == 3) begin
                n_cmp++; if (IMEM_REQ !== 1'b0 || INST_VALID !== 1'b1 || INST_PC !== 32'h4 || IMEM_RVALID !== 1'b1) begin
                    n_err++; $display("FAIL rrp_cycle: got req=%b v=%b pc=%h rv=%b want 0/1/4/1", IMEM_REQ, INST_VALID, INST_PC, IMEM_RVALID); end
            end
            if (c == 4) begin
                n_cmp++; if (INST_VALID !== 1'b0 || IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h40) begin
                    n_err++; $display("FAIL rrp_next: got v=%b req=%b addr=%h want 0/1/00000040", INST_VALID, IMEM_REQ, IMEM_ADDR); end
            end
            if (c == 5) begin
                n_cmp++; if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL rrp_gap: got v=%b want 0", INST_VALID); end
            end
            if (c >= 6) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'(32'h40 + 4 * (c - 6)) || INST !== INST_PC) begin
                    n_err++; $display("FAIL rrp_inst c%0d: got v=%b pc=%h inst=%h want pc %h", c, INST_VALID, INST_PC, INST, 32'(32'h40 + 4 * (c - 6))); end
            end
        end
        REDIRECT = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset(3);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge CLK);
            REDIRECT    = (c == 2 || c == 3);
            REDIRECT_PC = (c == 2) ? 32'h200 : 32'h300;
            #2;
            if (c == 4) begin
                n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h300) begin
                    n_err++; $display("FAIL b2b_addr: got %b/%h want 1/00000300", IMEM_REQ, IMEM_ADDR); end
            end
            if (c >= 4 && c <= 7) begin
                n_cmp++; if (INST_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_drop c%0d: got v=%b pc=%h want invalid", c, INST_VALID, INST_PC); end
            end
            if (c >= 8) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'(32'h300 + 4 * (c - 8))) begin
                    n_err++; $display("FAIL b2b_inst c%0d: got v=%b pc=%h want %h", c, INST_VALID, INST_PC, 32'(32'h300 + 4 * (c - 8))); end
            end
        end
        REDIRECT = 1'b0;
    endtask

    task automatic test_gnt_wrap();
        do_reset(1);
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge CLK);
            REDIRECT    = (c == 0);
            REDIRECT_PC = 32'hFFFF_FFFF;
            IMEM_GNT    = (c >= 5);
            #2;
            if (c >= 1 && c <= 5) begin
                n_cmp++; if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'hFFFF_FFFC) begin
                    n_err++; $display("FAIL gnt_hold c%0d: got %b/%h want 1/fffffffc", c, IMEM_REQ, IMEM_ADDR); end
            end
            if (c == 6) begin
                n_cmp++; if (IMEM_ADDR !== 32'h0) begin n_err++; $display("FAIL gnt_wrap_addr: got %h want 0", IMEM_ADDR); end
            end
            if (c == 7) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'hFFFF_FFFC) begin
                    n_err++; $display("FAIL gnt_wrap_inst0: got v=%b pc=%h want fffffffc", INST_VALID, INST_PC); end
            end
            if (c == 8) begin
                n_cmp++; if (INST_VALID !== 1'b1 || INST_PC !== 32'h0) begin
                    n_err++; $display("FAIL gnt_wrap_inst1: got v=%b pc=%h want 0", INST_VALID, INST_PC); end
            end
        end
        REDIRECT = 1'b0;
        IMEM_GNT = 1'b1;
    endtask

    task automatic test_jal();
        logic [31:0] seen[$];
        logic [31:0] exp_seq [4];
        logic        exp_req3;
`ifdef FETCH_JAL_PREDICT_EN
        exp_seq  = '{32'h0, 32'h4, 32'h8, 32'h18};
        exp_req3 = 1'b0;
`else
        exp_seq  = '{32'h0, 32'h4, 32'h8, 32'hC};
        exp_req3 = 1'b1;
`endif
        jal_at = 32'h8;
        do_reset(1);
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge CLK);
            #2;
            if (c == 3) begin
                n_cmp++; if (IMEM_REQ !== exp_req3) begin n_err++; $display("FAIL jal_req: got %b want %b", IMEM_REQ, exp_req3); end
            end
            if (INST_VALID === 1'b1) begin
                seen.push_back(INST_PC);
                if (INST_PC === 32'h8) begin
                    n_cmp++; if (INST !== JAL16) begin n_err++; $display("FAIL jal_word: got %h want %h", INST, JAL16); end
                end
            end
        end
        n_cmp++;
        if (seen.size() < 4) begin
            n_err++; $display("FAIL jal_count: got %0d presented want >= 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (seen[i] !== exp_seq[i]) begin
                    n_err++; $display("FAIL jal_seq[%0d]: got %h want %h", i, seen[i], exp_seq[i]); end
            end
        end
        jal_at = 32'hFFFF_FFFF;
    endtask

    initial begin
        RST_N = 1'b0; IMEM_GNT = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; STALL = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_resp_pop();
        test_back_to_back();
        test_gnt_wrap();
        test_jal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
